eth_forward_pkt_buffer: RTL and testbench

- Store-and-forward packet buffer for forwarded (transit) traffic, sitting directly upstream of the uplink port's forward input.
- Accepts 64-bit AXIS packets from the switching fabric. Commits only complete, error-free packets that fit.
- On the uplink's forward-ready grant, releases exactly one stored packet as an unbroken burst, holding the forward-packet-valid flag around it.

---
 rtl/eth_forward_pkt_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_eth_forward_pkt_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_forward_pkt_buffer.sv
// Store-and-forward buffer for transit traffic: commits complete, error-free packets
// and releases exactly one stored packet per uplink grant as an unbroken burst.
module eth_forward_pkt_buffer #(
  parameter int DATA_DEPTH    = 2048,
  parameter int DESC_DEPTH    = 16,
  parameter int MAX_PKT_WORDS = 190
) (
  input  logic                          i_data_clk,
  input  logic                          i_data_rst_n,
  input  logic                          s_axis_tvalid,
  input  logic [63:0]                   s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic [7:0]                    s_axis_tkeep,
  input  logic                          s_axis_tuser,
  output logic                          s_axis_tready,
  output logic                          o_forward_pkt_valid,
  input  logic                          i_forward_pkt_ready,
  output logic                          m_forward_axis_tvalid,
  output logic [63:0]                   m_forward_axis_tdata,
  output logic                          m_forward_axis_tlast,
  output logic [7:0]                    m_forward_axis_tkeep,
  output logic                          m_forward_axis_tuser,
  input  logic                          m_forward_axis_tready,
  output logic [$clog2(DESC_DEPTH):0]   o_pkt_cnt,
  output logic [15:0]                   o_drop_cnt
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int DW = $clog2(DESC_DEPTH);
  localparam int CW = DW + 1;

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND} rd_state_e;

  logic [63:0] mem [DATA_DEPTH];
  logic [23:0] desc_mem [DESC_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [AW-1:0] free_ptr_q, free_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_inc;
  logic [15:0]   beat_cnt_q, beat_cnt_d, drop_cnt_q, drop_cnt_d, new_cnt;
  logic          in_pkt_q, in_pkt_d, drop_q, drop_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [DW-1:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
  rd_state_e     state_q, state_d;
  logic [15:0]   rd_left_q, rd_left_d, out_left_q, out_left_d;
  logic [7:0]    last_keep_q, last_keep_d;
  logic          rd_vld_q;
  logic [63:0]   rd_data_q, ob0_q, ob0_d, ob1_q, ob1_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [2:0]    occ;
  logic          s_ready, acc, too_long, mem_full, bad_beat, mem_we, commit;
  logic          start, pop_beat, last_pop, rd_en;
  logic [23:0]   desc_head;

  // Ingress only stalls between packets; a started packet always drains.
  assign s_ready    = in_pkt_q | (pkt_cnt_q != CW'(DESC_DEPTH));
  assign acc        = s_axis_tvalid & s_ready;
  assign new_cnt    = beat_cnt_q + 16'd1;
  assign wr_ptr_inc = wr_ptr_q + AW'(1);
  assign too_long   = new_cnt > 16'(MAX_PKT_WORDS);
  assign mem_full   = (wr_ptr_inc == free_ptr_q);
  assign bad_beat   = drop_q | too_long | mem_full;
  assign mem_we     = acc & ~bad_beat;
  assign commit     = acc & s_axis_tlast & ~bad_beat & ~s_axis_tuser;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    beat_cnt_d  = beat_cnt_q;
    in_pkt_d    = in_pkt_q;
    drop_d      = drop_q;
    drop_cnt_d  = drop_cnt_q;
    desc_wr_d   = desc_wr_q;
    if (acc) begin
      in_pkt_d = ~s_axis_tlast;
      if (s_axis_tlast) begin
        beat_cnt_d = 16'd0;
        drop_d     = 1'b0;
        if (commit) begin
          wr_ptr_d    = wr_ptr_inc;
          wr_commit_d = wr_ptr_inc;
          desc_wr_d   = desc_wr_q + DW'(1);
        end else begin
          wr_ptr_d = wr_commit_q;
          if (drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end else begin
        if (!too_long) beat_cnt_d = new_cnt;
        if (bad_beat) drop_d = 1'b1;
        else          wr_ptr_d = wr_ptr_inc;
      end
    end
  end

  assign desc_head = desc_mem[desc_rd_q];
  assign start     = (state_q == IDLE) & i_forward_pkt_ready & (pkt_cnt_q != '0);
  assign pop_beat  = (state_q == SEND) & (ob_cnt_q != 2'd0) & m_forward_axis_tready;
  assign last_pop  = pop_beat & (out_left_q == 16'd1);
  // Reads are issued only when the 2-entry skid buffer can absorb them even under stall.
  assign occ       = {1'b0, ob_cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop_beat};
  assign rd_en     = start | ((state_q != IDLE) & (rd_left_q != 16'd0) & (occ <= 3'd1));

  always_comb begin
    state_d     = state_q;
    rd_left_d   = rd_left_q;
    out_left_d  = out_left_q;
    last_keep_d = last_keep_q;
    desc_rd_d   = desc_rd_q;
    rd_ptr_d    = rd_ptr_q;
    free_ptr_d  = free_ptr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = PREFETCH;
        desc_rd_d   = desc_rd_q + DW'(1);
        out_left_d  = desc_head[23:8];
        rd_left_d   = desc_head[23:8] - 16'd1;
        last_keep_d = desc_head[7:0];
      end
      PREFETCH: state_d = SEND;
      SEND: begin
        if (pop_beat) out_left_d = out_left_q - 16'd1;
        if (last_pop) begin
          state_d    = IDLE;
          free_ptr_d = rd_ptr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (!start) rd_left_d = rd_left_q - 16'd1;
    end
  end

  always_comb begin
    ob0_d    = ob0_q;
    ob1_d    = ob1_q;
    ob_cnt_d = ob_cnt_q;
    case ({rd_vld_q, pop_beat})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob0_d = rd_data_q;
        else                  ob1_d = rd_data_q;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b01: begin
        ob0_d    = ob1_q;
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) ob0_d = rd_data_q;
        else begin
          ob0_d = ob1_q;
          ob1_d = rd_data_q;
        end
      end
      default: ;
    endcase
  end

  assign pkt_cnt_d = pkt_cnt_q + CW'(commit) - CW'(last_pop);

  always_ff @(posedge i_data_clk) begin
    if (mem_we) mem[wr_ptr_q] <= s_axis_tdata;
    if (rd_en)  rd_data_q <= mem[rd_ptr_q];
    if (commit) desc_mem[desc_wr_q] <= {new_cnt, s_axis_tkeep};
  end

  always_ff @(posedge i_data_clk or negedge i_data_rst_n) begin
    if (!i_data_rst_n) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      free_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      in_pkt_q    <= 1'b0;
      drop_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      desc_wr_q   <= '0;
      desc_rd_q   <= '0;
      state_q     <= IDLE;
      rd_left_q   <= '0;
      out_left_q  <= '0;
      last_keep_q <= '0;
      rd_vld_q    <= 1'b0;
      ob0_q       <= '0;
      ob1_q       <= '0;
      ob_cnt_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      free_ptr_q  <= free_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      in_pkt_q    <= in_pkt_d;
      drop_q      <= drop_d;
      pkt_cnt_q   <= pkt_cnt_d;
      desc_wr_q   <= desc_wr_d;
      desc_rd_q   <= desc_rd_d;
      state_q     <= state_d;
      rd_left_q   <= rd_left_d;
      out_left_q  <= out_left_d;
      last_keep_q <= last_keep_d;
      rd_vld_q    <= rd_en;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
      ob_cnt_q    <= ob_cnt_d;
    end
  end

  assign s_axis_tready         = s_ready;
  assign o_forward_pkt_valid   = (state_q == SEND);
  assign m_forward_axis_tvalid = (state_q == SEND) & (ob_cnt_q != 2'd0);
  assign m_forward_axis_tdata  = m_forward_axis_tvalid ? ob0_q : 64'd0;
  assign m_forward_axis_tlast  = m_forward_axis_tvalid & (out_left_q == 16'd1);
  assign m_forward_axis_tkeep  = m_forward_axis_tlast ? last_keep_q : 8'hff;
  assign m_forward_axis_tuser  = 1'b0;
  assign o_pkt_cnt             = pkt_cnt_q;
  assign o_drop_cnt            = drop_cnt_q;
endmodule

// File: tb/tb_eth_forward_pkt_buffer.sv
// Directed bench for eth_forward_pkt_buffer: ingress driver, burst collector and
// per-scenario tasks comparing egress beats against an expected-beat queue.
module tb_eth_forward_pkt_buffer;
  localparam int DATA_DEPTH    = 256;
  localparam int DESC_DEPTH    = 16;
  localparam int MAX_PKT_WORDS = 190;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        o_forward_pkt_valid, i_forward_pkt_ready;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [4:0]  o_pkt_cnt;
  logic [15:0] o_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  // Beat entries are {tlast, tkeep, tdata}.
  logic [72:0] exp_q[$];
  logic [72:0] cap_q[$];

  eth_forward_pkt_buffer #(
    .DATA_DEPTH(DATA_DEPTH), .DESC_DEPTH(DESC_DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)
  ) dut (
    .i_data_clk(clk), .i_data_rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .o_forward_pkt_valid(o_forward_pkt_valid), .i_forward_pkt_ready(i_forward_pkt_ready),
    .m_forward_axis_tvalid(m_tvalid), .m_forward_axis_tdata(m_tdata),
    .m_forward_axis_tlast(m_tlast), .m_forward_axis_tkeep(m_tkeep),
    .m_forward_axis_tuser(m_tuser), .m_forward_axis_tready(m_tready),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] beat_data(input logic [15:0] tag, input int i);
    return {tag, 16'hc0de, 32'(i)};
  endfunction

  // Drives one packet; beats are handed over on the posedge after each negedge setup.
  task automatic send_pkt(input logic [15:0] tag, input int len, input logic [7:0] keep,
                          input bit err, input bit fwd);
    int guard;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(tag, i);
      s_axis_tlast  = (i == len - 1);
      s_axis_tkeep  = (i == len - 1) ? keep : 8'hff;
      s_axis_tuser  = (i == len - 1) ? err : 1'b0;
      guard = 0;
      while (!s_axis_tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!s_axis_tready) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: tag %h beat %0d tready=%b required 1", tag, i, s_axis_tready);
        break;
      end
      if (fwd) exp_q.push_back({(i == len - 1), (i == len - 1) ? keep : 8'hff, beat_data(tag, i)});
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Raises the grant, waits for a burst and records every handshaken beat into cap_q.
  task automatic collect_burst(input bit hold, input bit toggle, output bit timed_out,
                               output int lat, output bit gap, output bit tail_ok);
    bit done;
    int guard;
    timed_out = 1'b0; gap = 1'b0; tail_ok = 1'b0; lat = 0;
    cap_q.delete();
    @(negedge clk);
    i_forward_pkt_ready = 1'b1;
    m_tready = 1'b1;
    while (!o_forward_pkt_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!o_forward_pkt_valid) begin
      timed_out = 1'b1;
      i_forward_pkt_ready = hold;
      return;
    end
    if (!hold) i_forward_pkt_ready = 1'b0;
    done = 1'b0; guard = 0;
    while (!done && guard < 2000) begin
      m_tready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_tvalid || !o_forward_pkt_valid) gap = 1'b1;
      else if (m_tready) begin
        cap_q.push_back({m_tlast, m_tkeep, m_tdata});
        if (m_tlast) done = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    if (!done) timed_out = 1'b1;
    tail_ok = !o_forward_pkt_valid && !m_tvalid;
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_axis_tready, o_forward_pkt_valid, m_tvalid, m_tlast, m_tuser, m_tkeep} !== 13'b1_0_0_0_0_11111111) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 1000011111111",
               {s_axis_tready, o_forward_pkt_valid, m_tvalid, m_tlast, m_tuser, m_tkeep});
    end
    n_cmp++;
    if (m_tdata !== 64'd0) begin n_err++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    n_cmp++;
    if (o_pkt_cnt !== 5'd0) begin n_err++; $display("FAIL reset_pkt_cnt: got %0d required 0", o_pkt_cnt); end
    n_cmp++;
    if (o_drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d required 0", o_drop_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pkt();
    bit to, gap, tail;
    int lat, bad;
    send_pkt(16'h0001, 8, 8'h0f, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (o_pkt_cnt !== 5'd1) begin n_err++; $display("FAIL single_cnt_before: got %0d required 1", o_pkt_cnt); end
    collect_burst(1'b0, 1'b0, to, lat, gap, tail);
    n_cmp++;
    if (to || lat > 3) begin n_err++; $display("FAIL single_latency: timeout=%0d lat=%0d required <=3", to, lat); end
    bad = 0;
    foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    n_cmp++;
    if (bad != 0 || cap_q.size() != 8 || gap) begin
      n_err++;
      $display("FAIL single_data: beats %0d bad %0d gap %0d required 8/0/0", cap_q.size(), bad, gap);
    end
    n_cmp++;
    if (cap_q.size() < 8 || cap_q[7][72:64] !== 9'h10f) begin
      n_err++;
      $display("FAIL single_last_beat: got %h required 10f", (cap_q.size() < 8) ? 9'h0 : cap_q[7][72:64]);
    end
    n_cmp++;
    if (!tail) begin n_err++; $display("FAIL single_tail: valid still high after tlast, required low"); end
    n_cmp++;
    if (o_pkt_cnt !== 5'd0) begin n_err++; $display("FAIL single_cnt_after: got %0d required 0", o_pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to, gap, tail;
    int lat, bad;
    int lens[3] = '{5, 1, 9};
    send_pkt(16'h0002, 5, 8'h01, 1'b0, 1'b1);
    send_pkt(16'h0003, 1, 8'h7f, 1'b0, 1'b1);
    send_pkt(16'h0004, 9, 8'hff, 1'b0, 1'b1);
    n_cmp++;
    if (o_pkt_cnt !== 5'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d required 3", o_pkt_cnt); end
    for (int p = 0; p < 3; p++) begin
      collect_burst(1'b1, 1'b1, to, lat, gap, tail);
      bad = 0;
      foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
      n_cmp++;
      if (to || gap || !tail || bad != 0 || cap_q.size() != lens[p]) begin
        n_err++;
        $display("FAIL b2b_burst%0d: to=%0d gap=%0d tail=%0d bad=%0d beats=%0d required 0/0/1/0/%0d",
                 p, to, gap, tail, bad, cap_q.size(), lens[p]);
      end
    end
    i_forward_pkt_ready = 1'b0;
    n_cmp++;
    if (o_pkt_cnt !== 5'd0) begin n_err++; $display("FAIL b2b_cnt_after: got %0d required 0", o_pkt_cnt); end
  endtask

  task automatic test_error_drop();
    bit to, gap, tail;
    int lat, bad;
    send_pkt(16'h0005, 4, 8'h03, 1'b0, 1'b1);
    send_pkt(16'h0006, 6, 8'hff, 1'b1, 1'b0);
    send_pkt(16'h0007, 3, 8'h1f, 1'b0, 1'b1);
    n_cmp++;
    if (o_drop_cnt !== 16'd1 || o_pkt_cnt !== 5'd2) begin
      n_err++;
      $display("FAIL err_counts: drop %0d pkt %0d required 1/2", o_drop_cnt, o_pkt_cnt);
    end
    bad = 0;
    for (int p = 0; p < 2; p++) begin
      collect_burst(1'b0, 1'b0, to, lat, gap, tail);
      if (to || !tail || cap_q.size() != ((p == 0) ? 4 : 3)) bad++;
      foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    end
    n_cmp++;
    if (bad != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL err_bursts: bad %0d leftover %0d required 0/0", bad, exp_q.size());
    end
  endtask

  task automatic test_oversize();
    bit to, gap, tail;
    int lat, bad;
    send_pkt(16'h0008, 191, 8'hff, 1'b0, 1'b0);
    send_pkt(16'h0009, 190, 8'h3f, 1'b0, 1'b1);
    n_cmp++;
    if (o_drop_cnt !== 16'd2 || o_pkt_cnt !== 5'd1) begin
      n_err++;
      $display("FAIL oversize_counts: drop %0d pkt %0d required 2/1", o_drop_cnt, o_pkt_cnt);
    end
    collect_burst(1'b0, 1'b0, to, lat, gap, tail);
    bad = 0;
    foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    n_cmp++;
    if (to || gap || !tail || bad != 0 || cap_q.size() != 190) begin
      n_err++;
      $display("FAIL oversize_burst: to=%0d gap=%0d bad=%0d beats=%0d required 0/0/0/190",
               to, gap, bad, cap_q.size());
    end
  endtask

  task automatic test_desc_full();
    bit to, gap, tail;
    int lat, bad;
    for (int p = 0; p < DESC_DEPTH; p++) send_pkt(16'h0100 + 16'(p), 2, 8'h01, 1'b0, 1'b1);
    n_cmp++;
    if (o_pkt_cnt !== 5'd16 || s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL full_stall: pkt %0d tready %b required 16/0", o_pkt_cnt, s_axis_tready);
    end
    collect_burst(1'b0, 1'b0, to, lat, gap, tail);
    bad = 0;
    if (to || cap_q.size() != 2) bad++;
    foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    n_cmp++;
    if (bad != 0 || o_pkt_cnt !== 5'd15 || s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL full_release: bad %0d pkt %0d tready %b required 0/15/1", bad, o_pkt_cnt, s_axis_tready);
    end
    bad = 0;
    for (int p = 1; p < DESC_DEPTH; p++) begin
      collect_burst(1'b0, 1'b0, to, lat, gap, tail);
      if (to || cap_q.size() != 2) bad++;
      foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    end
    n_cmp++;
    if (bad != 0 || o_pkt_cnt !== 5'd0) begin
      n_err++;
      $display("FAIL full_drain: bad %0d pkt %0d required 0/0", bad, o_pkt_cnt);
    end
  endtask

  task automatic test_wrap();
    bit to, gap, tail;
    int lat, bad;
    bad = 0;
    for (int p = 0; p < 30; p++) begin
      send_pkt(16'h0200 + 16'(p), 12, 8'hff >> (p % 8), 1'b0, 1'b1);
      collect_burst(1'b0, 1'b0, to, lat, gap, tail);
      if (to || gap || !tail || cap_q.size() != 12) bad++;
      foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    end
    n_cmp++;
    if (bad != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_data: bad %0d leftover %0d required 0/0", bad, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_send();
    bit to, gap, tail;
    int lat, bad, guard;
    send_pkt(16'h0300, 10, 8'hff, 1'b0, 1'b1);
    send_pkt(16'h0301, 4, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    i_forward_pkt_ready = 1'b1;
    guard = 0;
    while (!o_forward_pkt_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!o_forward_pkt_valid) begin n_err++; $display("FAIL rst_burst_start: valid 0 required 1"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_axis_tready, o_forward_pkt_valid, m_tvalid, m_tlast, m_tkeep} !== 12'b1_0_0_0_11111111 ||
        m_tdata !== 64'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: flags %b data %h required 100011111111/0",
               {s_axis_tready, o_forward_pkt_valid, m_tvalid, m_tlast, m_tkeep}, m_tdata);
    end
    n_cmp++;
    if (o_pkt_cnt !== 5'd0 || o_drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_counts: pkt %0d drop %0d required 0/0", o_pkt_cnt, o_drop_cnt);
    end
    i_forward_pkt_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(16'h0302, 3, 8'h07, 1'b0, 1'b1);
    n_cmp++;
    if (o_pkt_cnt !== 5'd1) begin n_err++; $display("FAIL rst_post_cnt: got %0d required 1", o_pkt_cnt); end
    collect_burst(1'b0, 1'b0, to, lat, gap, tail);
    bad = 0;
    foreach (cap_q[i]) if (exp_q.size() == 0 || cap_q[i] !== exp_q.pop_front()) bad++;
    n_cmp++;
    if (to || bad != 0 || cap_q.size() != 3) begin
      n_err++;
      $display("FAIL rst_post_burst: to=%0d bad=%0d beats=%0d required 0/0/3", to, bad, cap_q.size());
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    s_axis_tvalid       = 1'b0;
    s_axis_tdata        = 64'd0;
    s_axis_tlast        = 1'b0;
    s_axis_tkeep        = 8'h00;
    s_axis_tuser        = 1'b0;
    i_forward_pkt_ready = 1'b0;
    m_tready            = 1'b1;
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_error_drop();
    test_oversize();
    test_desc_full();
    test_wrap();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
